// File: rtl/maxpool_pkg.sv
// Shared definitions for the pooling / unpooling datapath family.
package maxpool_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_SIZE   = 100;

    typedef enum logic {
        PASS   = 1'b0,
        REPLAY = 1'b1
    } pool_state_e;

    // Index width for a counter/address covering 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// Single-write-port register line buffer with an asynchronous (combinational) read port.
module upsample_line_buf
    import maxpool_pkg::*;
#(
    parameter int DEPTH      = DEF_IMG_SIZE / 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int AW        = idx_width(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Wr_En,
    input  logic [AW-1:0]         Wr_Addr,
    input  logic [DATA_WIDTH-1:0] Wr_Data,
    input  logic [AW-1:0]         Rd_Addr,
    output logic [DATA_WIDTH-1:0] Rd_Data
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (Wr_En) begin
            mem_q[Wr_Addr] <= Wr_Data;
        end
    end

    assign Rd_Data = mem_q[Rd_Addr];

endmodule

// File: rtl/upsample2x_nn.sv
// Nearest-neighbour 2x upsampler: each pooled pixel is emitted twice per row and each
// pooled row twice, the second row copy being replayed from an internal line buffer.
module upsample2x_nn
    import maxpool_pkg::*;
#(
    parameter int IMG_SIZE   = DEF_IMG_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Out_Row_Odd,
    output logic                  Out_Last
);

    localparam int HALF = IMG_SIZE / 2;
    localparam int CW   = idx_width(HALF + 1);
    localparam int AW   = idx_width(HALF);
    localparam int RW   = idx_width(IMG_SIZE);

    localparam logic [CW-1:0] COL_END  = CW'(HALF);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_SIZE - 1);

    pool_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  dup_phase_q, dup_phase_d;
    // Number of pooled pixels loaded into Hold in the current row (0..HALF);
    // Hold's column is col_cnt_q-1, and col_cnt_q doubles as the buffer write/read index.
    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;

    logic                  out_xfer;
    logic                  free;
    logic                  row_end;
    logic [CW-1:0]         col_base;
    logic                  can_load;
    logic                  in_ready;
    logic                  in_xfer;
    logic                  replay_load;
    logic [AW-1:0]         buf_addr;
    logic [DATA_WIDTH-1:0] buf_rd_data;

    upsample_line_buf #(
        .DEPTH      (HALF),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .Clk     (Clk),
        .Wr_En   (in_xfer),
        .Wr_Addr (buf_addr),
        .Wr_Data (In_Data),
        .Rd_Addr (buf_addr),
        .Rd_Data (buf_rd_data)
    );

    always_comb begin
        out_xfer = hold_valid_q && Out_Ready;
        free     = !hold_valid_q || (Out_Ready && dup_phase_q && hold_valid_q);
        row_end  = out_xfer && dup_phase_q && (col_cnt_q == COL_END);

        // A row boundary retargets the same-cycle reload to the new state and column 0.
        state_d  = state_q;
        if (row_end) begin
            state_d = (state_q == PASS) ? REPLAY : PASS;
        end
        col_base    = row_end ? '0 : col_cnt_q;
        can_load    = free && (col_base < COL_END);
        in_ready    = can_load && (state_d == PASS);
        in_xfer     = In_Valid && in_ready;
        replay_load = can_load && (state_d == REPLAY);
        buf_addr    = can_load ? col_base[AW-1:0] : '0;

        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        dup_phase_d  = dup_phase_q;
        col_cnt_d    = col_cnt_q;
        if (in_xfer) begin
            hold_data_d  = In_Data;
            hold_valid_d = 1'b1;
            dup_phase_d  = 1'b0;
            col_cnt_d    = col_base + CW'(1);
        end else if (replay_load) begin
            hold_data_d  = buf_rd_data;
            hold_valid_d = 1'b1;
            dup_phase_d  = 1'b0;
            col_cnt_d    = col_base + CW'(1);
        end else if (free) begin
            hold_valid_d = 1'b0;
            dup_phase_d  = 1'b0;
            col_cnt_d    = col_base;
        end else if (out_xfer) begin
            dup_phase_d  = 1'b1;
        end

        row_cnt_d = row_cnt_q;
        if (row_end) begin
            row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= PASS;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            dup_phase_q  <= 1'b0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            dup_phase_q  <= dup_phase_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
        end
    end

    assign In_Ready    = in_ready;
    assign Out_Data    = hold_data_q;
    assign Out_Valid   = hold_valid_q;
    assign Out_Row_Odd = row_cnt_q[0];
    assign Out_Last    = hold_valid_q && dup_phase_q && (col_cnt_q == COL_END)
                         && (row_cnt_q == ROW_LAST);

endmodule

// File: tb/tb_upsample2x_nn.sv
// Bench for upsample2x_nn: a 4x4 instance for directed cases and a 100x100 instance for a random frame.
module tb_upsample2x_nn;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid  [2];
    logic [DW-1:0] in_data   [2];
    logic          in_ready  [2];
    logic [DW-1:0] out_data  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          out_odd   [2];
    logic          out_last  [2];

    upsample2x_nn #(.IMG_SIZE(4), .DATA_WIDTH(DW)) dut_small (
        .Clk(clk), .Rst(rst_n),
        .In_Data(in_data[0]), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
        .Out_Data(out_data[0]), .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]),
        .Out_Row_Odd(out_odd[0]), .Out_Last(out_last[0])
    );

    upsample2x_nn #(.IMG_SIZE(100), .DATA_WIDTH(DW)) dut_big (
        .Clk(clk), .Rst(rst_n),
        .In_Data(in_data[1]), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
        .Out_Data(out_data[1]), .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]),
        .Out_Row_Odd(out_odd[1]), .Out_Last(out_last[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model state: accepted pixels in order and the index of the next output beat since reset.
    logic [DW-1:0] in_mem [2][4096];
    int            n_in   [2];
    int            k      [2];
    logic          prev_xfer  [2];
    logic          prev_stall [2];
    logic [DW-1:0] prev_data  [2];
    int            mode       [2];

    int   lg_n;
    int   lg_data [64];
    logic lg_odd  [64];
    logic lg_last [64];
    int   last_cnt;

    int          exp_a [16] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
    int          exp_c [16] = '{5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8};
    int          exp_e [16] = '{9,9,10,10,9,9,10,10,11,11,12,12,11,11,12,12};
    logic [15:0] odd_pat    = 16'hF0F0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // out(r,c) of frame f must be in(f, r/2, c/2); rows odd are replays.
    task automatic monitor_inst(input int g);
        int n, half, f, p, r, c, idx;
        n    = (g == 0) ? 4 : 100;
        half = n / 2;
        if (!rst_n) begin
            prev_xfer[g]  = 1'b0;
            prev_stall[g] = 1'b0;
        end else begin
            f   = k[g] / (n * n);
            p   = k[g] % (n * n);
            r   = p / n;
            c   = p % n;
            idx = f * half * half + (r / 2) * half + c / 2;
            if (prev_stall[g]) begin
                chk("stall_valid", int'(out_valid[g]), 1);
                chk("stall_data", int'(out_data[g]), int'(prev_data[g]));
            end
            if (c % 2 == 1) chk("pair_valid", int'(out_valid[g]), 1);
            if (r % 2 == 1 && prev_xfer[g]) chk("replay_no_bubble", int'(out_valid[g]), 1);
            if (out_valid[g]) begin
                chk("row_odd", int'(out_odd[g]), r % 2);
                chk("last", int'(out_last[g]), int'(r == n - 1 && c == n - 1));
                if (idx < n_in[g]) chk("data", int'(out_data[g]), int'(in_mem[g][idx]));
                else chk("data_early", n_in[g], idx + 1);
                if (!out_ready[g]) chk("in_ready_stall", int'(in_ready[g]), 0);
                if (r % 2 == 1 && c != n - 1) chk("in_ready_replay", int'(in_ready[g]), 0);
            end else begin
                chk("in_ready_idle", int'(in_ready[g]), 1);
            end
            prev_stall[g] = out_valid[g] && !out_ready[g];
            prev_xfer[g]  = out_valid[g] && out_ready[g];
            prev_data[g]  = out_data[g];
            if (out_valid[g] && out_ready[g]) begin
                if (g == 0) begin
                    if (lg_n < 64) begin
                        lg_data[lg_n] = int'(out_data[g]);
                        lg_odd[lg_n]  = out_odd[g];
                        lg_last[lg_n] = out_last[g];
                        lg_n++;
                    end
                    if (out_last[g]) last_cnt++;
                end
                k[g]++;
            end
            if (in_valid[g] && in_ready[g]) begin
                if (n_in[g] < 4096) in_mem[g][n_in[g]] = in_data[g];
                n_in[g]++;
            end
        end
    endtask

    task automatic send(input int g, input int v, input int gap);
        int t;
        t = 0;
        in_valid[g] = 1'b1;
        in_data[g]  = DW'(v);
        @(negedge clk);
        while (!in_ready[g] && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready[g]) chk("send_timeout", t, 0);
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats(input int g, input int target, input string nm);
        int t;
        t = 0;
        while (k[g] < target && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(k[g] >= target), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            k[g]    = 0;
            n_in[g] = 0;
        end
        lg_n = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid[g]   = 1'b0;
            in_data[g]    = '0;
            out_ready[g]  = 1'b1;
            mode[g]       = 0;
            prev_xfer[g]  = 1'b0;
            prev_stall[g] = 1'b0;
            prev_data[g]  = '0;
        end
        last_cnt = 0;
        model_reset();
        fork
            forever begin
                @(negedge clk);
                monitor_inst(0);
                monitor_inst(1);
            end
            forever begin
                @(posedge clk);
                #1;
                for (int g = 0; g < 2; g++) begin
                    case (mode[g])
                        0:       out_ready[g] = 1'b1;
                        1:       out_ready[g] = ~out_ready[g];
                        default: out_ready[g] = 1'($urandom_range(0, 1));
                    endcase
                end
            end
            begin
                #1;
                chk("rst_out_valid", int'(out_valid[0]), 0);
                chk("rst_out_last", int'(out_last[0]), 0);
                chk("rst_out_odd", int'(out_odd[0]), 0);
                chk("rst_out_data", int'(out_data[0]), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_in_ready", int'(in_ready[0]), 1);
                @(posedge clk);
                #1;

                // One frame, Out_Ready held high.
                lg_n = 0;
                for (int i = 1; i <= 4; i++) send(0, i, 0);
                wait_beats(0, 16, "frame_a_timeout");
                for (int i = 0; i < 16; i++) begin
                    chk("a_data", lg_data[i], exp_a[i]);
                    chk("a_odd", int'(lg_odd[i]), int'(odd_pat[i]));
                    chk("a_last", int'(lg_last[i]), int'(i == 15));
                end
                @(negedge clk);
                chk("idle_after_frame", int'(out_valid[0]), 0);
                @(posedge clk);
                #1;

                // Same frame with Out_Ready alternating.
                mode[0] = 1;
                lg_n = 0;
                for (int i = 1; i <= 4; i++) send(0, i, 0);
                wait_beats(0, 32, "frame_b_timeout");
                for (int i = 0; i < 16; i++) chk("b_data", lg_data[i], exp_a[i]);
                mode[0] = 0;

                // Input gaps of three cycles.
                lg_n = 0;
                for (int i = 5; i <= 8; i++) send(0, i, 3);
                wait_beats(0, 48, "frame_c_timeout");
                for (int i = 0; i < 16; i++) chk("c_data", lg_data[i], exp_c[i]);

                // Two frames back to back.
                lg_n = 0;
                last_cnt = 0;
                for (int i = 1; i <= 8; i++) send(0, i, 0);
                wait_beats(0, 80, "frame_d_timeout");
                chk("d_last_count", last_cnt, 2);
                for (int i = 0; i < 32; i++) begin
                    chk("d_data", lg_data[i], (i < 16) ? exp_a[i] : exp_c[i - 16]);
                    chk("d_odd", int'(lg_odd[i]), int'(odd_pat[i % 16]));
                end

                // Reset in the middle of a replay row.
                for (int i = 1; i <= 2; i++) send(0, i, 0);
                wait_beats(0, 86, "pre_reset_timeout");
                rst_n = 1'b0;
                #1;
                chk("mid_rst_out_valid", int'(out_valid[0]), 0);
                chk("mid_rst_out_last", int'(out_last[0]), 0);
                chk("mid_rst_out_odd", int'(out_odd[0]), 0);
                chk("mid_rst_out_data", int'(out_data[0]), 0);
                model_reset();
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_in_ready", int'(in_ready[0]), 1);
                chk("post_rst_out_valid", int'(out_valid[0]), 0);
                @(posedge clk);
                #1;
                for (int i = 9; i <= 12; i++) send(0, i, 0);
                wait_beats(0, 16, "frame_e_timeout");
                for (int i = 0; i < 16; i++) chk("e_data", lg_data[i], exp_e[i]);

                // Full-size frame with random data and random Out_Ready.
                mode[1] = 2;
                for (int i = 0; i < 2500; i++) send(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
                wait_beats(1, 10000, "big_frame_timeout");
                chk("big_inputs", n_in[1], 2500);
                chk("big_outputs", k[1], 10000);
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/upsample2x_nn.md
Name: upsample2x_nn

Overview:
Nearest-neighbour 2x upsampler, the inverse of the maxpool2d 2x2/s2 path. Consumes a pooled raster stream of (IMG_SIZE/2)x(IMG_SIZE/2) pixels and emits an IMG_SIZE x IMG_SIZE raster stream. Each input pixel is repeated twice horizontally, and each pooled row is emitted twice vertically. The second copy of each row is replayed from an internal line buffer, so upstream supplies each pixel exactly once.

Parameters:
IMG_SIZE, 100, output image width/height in pixels; must be even, >= 2
DATA_WIDTH, 8, pixel width in bits

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  reset, asynchronous, active-low
In_Data  input  DATA_WIDTH  pooled pixel
In_Valid  input  1  In_Data valid
In_Ready  output  1  block accepts In_Data this cycle
Out_Data  output  DATA_WIDTH  upsampled pixel
Out_Valid  output  1  Out_Data valid
Out_Ready  input  1  downstream accepts Out_Data
Out_Row_Odd  output  1  output row index of current Out_Data is odd (replay row)
Out_Last  output  1  Out_Data is final pixel of frame, (IMG_SIZE-1, IMG_SIZE-1)

Behaviour:
- Constants: HALF = IMG_SIZE/2; line buffer = HALF entries x DATA_WIDTH, register array, combinational read.
- Transfers: input transfer = In_Valid && In_Ready; output transfer = Out_Valid && Out_Ready.
- Holding stage: Hold_Data, Hold_Valid, Dup_Phase (0 = first horizontal copy, 1 = second). Out_Data = Hold_Data, Out_Valid = Hold_Valid.
  - An output transfer with Dup_Phase=0 sets Dup_Phase=1; Hold stays valid.
  - An output transfer with Dup_Phase=1 clears Dup_Phase and frees Hold.
- Hold free condition: Free = !Hold_Valid || (Out_Ready && Dup_Phase && Hold_Valid).
- Counters:
  - Col_Idx, 0..HALF-1: pooled column index of Hold.
  - Row_Cnt, 0..IMG_SIZE-1: output row; Out_Row_Odd = Row_Cnt[0].
  - Wr_Idx/Rd_Idx share Col_Idx.
- FSM states PASS and REPLAY; reset state is PASS.
- PASS (even output rows):
  - In_Ready = Free.
  - On input transfer: Hold_Data <= In_Data, Hold_Valid <= 1, Dup_Phase <= 0, Line_Buf[Wr_Idx] <= In_Data, Wr_Idx advances. Wr_Idx wraps to 0 after HALF-1.
  - Free with no input transfer: Hold_Valid <= 0 (bubble).
- REPLAY (odd output rows):
  - In_Ready = 0.
  - When Free and Rd_Idx < HALF: Hold_Data <= Line_Buf[Rd_Idx], Hold_Valid <= 1, Rd_Idx advances.
  - No bubble inserted if Out_Ready stays high.
- Row transitions (taken on the output transfer with Dup_Phase=1 of the last column, HALF-1):
  - PASS -> REPLAY; Row_Cnt += 1.
  - REPLAY -> PASS; Row_Cnt += 1.
  - At Row_Cnt = IMG_SIZE-1, Row_Cnt wraps to 0 and a new frame starts.
  - The same-cycle Hold reload uses the new state. PASS->REPLAY loads Line_Buf[0] that cycle. REPLAY->PASS may accept new input that cycle.
- Out_Last = Hold_Valid && Dup_Phase && Col_Idx==HALF-1 && Row_Cnt==IMG_SIZE-1.
- Latency: input accepted at cycle t gives Out_Valid with that pixel at t+1.
- Steady-state throughput with Out_Ready=1: one output per cycle; one input per 2 cycles in PASS; zero inputs for IMG_SIZE cycles in REPLAY.
- Backpressure: Out_Ready=0 holds Out_Data/Out_Valid/Dup_Phase stable; In_Ready=0 while Hold is occupied and not freeing.
- Reset (any time, mid-row or mid-frame):
  - Hold_Valid=0, Dup_Phase=0, counters=0, state=PASS.
  - Outputs: Out_Valid=0, Out_Last=0, Out_Row_Odd=0, Out_Data=0, In_Ready=1 after reset.
  - Line buffer contents not reset (don't-care).
- Counter widths: $clog2(IMG_SIZE) for Row_Cnt, $clog2(HALF) (min 1) for Col_Idx.
- No arithmetic on pixel data.

Decomposition:
- Shared package maxpool_pkg: pixel width default, IMG_SIZE default, and a state enum {PASS, REPLAY} shared with future unpool variants.
- One natural sub-module: upsample_line_buf (HALF-deep register array, single write port, asynchronous read), reusable by other line-based blocks.

Test Plan:
- IMG_SIZE=4, Out_Ready=1, inputs 1,2,3,4 back-to-back -> Out_Data 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. Out_Row_Odd pattern 0000 1111 0000 1111. Out_Last only on the 16th beat. In_Ready low during rows 1 and 3.
- Same stimulus, Out_Ready toggled 1,0 every cycle -> identical data sequence, Out_Data stable while Out_Ready=0, no input accepted while Hold occupied.
- In_Valid gaps of 3 cycles between pixels in PASS -> Out_Valid bubbles in even rows only; odd-row replay continuous, 4 beats, no bubbles.
- Two frames back-to-back (inputs 1..4 then 5..8) -> second frame starts with 5,5,6,6, Row_Cnt wraps 3->0, Out_Last asserted exactly twice.
- Rst pulsed low mid-REPLAY (after 6 output beats) -> Out_Valid=0 immediately. After release, In_Ready=1, state PASS, next inputs 9,10,11,12 yield 9,9,10,10,9,9,10,10,...
- IMG_SIZE=100 default, random data, random Out_Ready -> 10000 outputs per 2500 inputs. Scoreboard confirms out(r,c) = in(r/2,c/2).
